uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out handshake bundle for uart_tx_fifo.
// slave is the transmitter side; master is the producer or bench side.
interface uart_tx_fifo_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Ready;
  logic       o_TX_Overflow;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;

  modport slave (
    input  i_TX_DV,
    input  i_TX_Byte,
    output o_TX_Ready,
    output o_TX_Overflow,
    output o_TX_Active,
    output o_TX_Serial,
    output o_TX_Done
  );

  modport master (
    output i_TX_DV,
    output i_TX_Byte,
    input  o_TX_Ready,
    input  o_TX_Overflow,
    input  o_TX_Active,
    input  o_TX_Serial,
    input  o_TX_Done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Line, activity, done and overflow outputs are registered from the current state.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_fifo_if.slave tx
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned BaudW  = $clog2(CLKS_PER_BIT);
  localparam logic [CountW-1:0] Full     = CountW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0]  BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]  count_q, count_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               wr_en, pop, baud_last;

  // Full is judged on the registered count, so a pop in the same cycle cannot rescue a write.
  assign wr_en     = tx.i_TX_DV && (count_q < Full);
  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    serial_d   = 1'b1;
    active_d   = 1'b0;
    done_d     = 1'b0;
    pop        = 1'b0;
    overflow_d = tx.i_TX_DV && !wr_en;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        baud_d   = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) state_d = StData;
      end
      StData: begin
        serial_d = shift_q[0];
        active_d = 1'b1;
        baud_d   = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        serial_d = 1'b1;
        active_d = 1'b1;
        baud_d   = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) count_d = count_q + 1'b1;
    if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: count and pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= tx.i_TX_Byte;
  end

  assign tx.o_TX_Ready    = (count_q < Full);
  assign tx.o_TX_Overflow = overflow_q;
  assign tx.o_TX_Active   = active_q;
  assign tx.o_TX_Serial   = serial_q;
  assign tx.o_TX_Done     = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Single-frame table plus hand-written streams for burst, overflow, back-to-back and reset.
module tb_uart_tx_fifo;
  localparam int Cpb = 4;

  logic CLK;
  logic RST;
  uart_tx_fifo_if tx_if ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .tx (tx_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int failures;

  // Frame bits in line order: [9]=start, [8:1]=data bit0..bit7, [0]=stop.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  // Stream description: writes, expected frame starts, overflow times, ready checkpoints.
  int         wr_t[8];
  logic [7:0] wr_b[8];
  int         n_wr;
  int         fr_start[8];
  logic [7:0] fr_byte[8];
  int         n_fr;
  int         ovf_t[4];
  int         n_ovf;
  int         rdy_t[8];
  logic       rdy_v[8];
  int         n_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stream();
    n_wr = 0; n_fr = 0; n_ovf = 0; n_rdy = 0;
  endtask

  function automatic void expect_at(input int t, output logic s, output logic a,
                                    output logic d);
    int k, idx;
    s = 1'b1; a = 1'b0; d = 1'b0;
    for (int f = 0; f < n_fr; f++) begin
      if (t >= fr_start[f] && t < fr_start[f] + 10 * Cpb) begin
        k   = t - fr_start[f];
        idx = k / Cpb;
        a   = 1'b1;
        d   = (k == 10 * Cpb - 1);
        if (idx == 0) s = 1'b0;
        else if (idx == 9) s = 1'b1;
        else s = fr_byte[f][idx-1];
      end
    end
  endfunction

  // t counts samples taken just after rising edge E+t, where E is the first edge of the stream.
  task automatic run_stream(input int n_cyc);
    logic es, ea, ed, eo;
    for (int t = 0; t < n_cyc; t++) begin
      tx_if.i_TX_DV   = 1'b0;
      tx_if.i_TX_Byte = 8'h00;
      for (int w = 0; w < n_wr; w++) begin
        if (wr_t[w] == t) begin
          tx_if.i_TX_DV   = 1'b1;
          tx_if.i_TX_Byte = wr_b[w];
        end
      end
      @(negedge CLK);
      expect_at(t, es, ea, ed);
      chk("stream_serial", {31'd0, tx_if.o_TX_Serial}, {31'd0, es});
      chk("stream_active", {31'd0, tx_if.o_TX_Active}, {31'd0, ea});
      chk("stream_done", {31'd0, tx_if.o_TX_Done}, {31'd0, ed});
      eo = 1'b0;
      for (int o = 0; o < n_ovf; o++) if (ovf_t[o] == t) eo = 1'b1;
      chk("stream_overflow", {31'd0, tx_if.o_TX_Overflow}, {31'd0, eo});
      for (int r = 0; r < n_rdy; r++) begin
        if (rdy_t[r] == t) chk("stream_ready", {31'd0, tx_if.o_TX_Ready}, {31'd0, rdy_v[r]});
      end
    end
    tx_if.i_TX_DV = 1'b0;
  endtask

  task automatic send_single(input vec_t v);
    tx_if.i_TX_DV   = 1'b1;
    tx_if.i_TX_Byte = v.data;
    @(negedge CLK);
    tx_if.i_TX_DV = 1'b0;
    chk("lat_e0_serial", {31'd0, tx_if.o_TX_Serial}, 32'd1);
    chk("lat_e0_ready", {31'd0, tx_if.o_TX_Ready}, 32'd1);
    @(negedge CLK);
    chk("lat_e1_serial", {31'd0, tx_if.o_TX_Serial}, 32'd1);
    chk("lat_e1_active", {31'd0, tx_if.o_TX_Active}, 32'd0);
    for (int c = 0; c < 10 * Cpb; c++) begin
      @(negedge CLK);
      chk("frame_serial", {31'd0, tx_if.o_TX_Serial}, {31'd0, v.frame[9 - c / Cpb]});
      chk("frame_active", {31'd0, tx_if.o_TX_Active}, 32'd1);
      chk("frame_done", {31'd0, tx_if.o_TX_Done}, {31'd0, c == 10 * Cpb - 1});
    end
    repeat (2) begin
      @(negedge CLK);
      chk("post_serial", {31'd0, tx_if.o_TX_Serial}, 32'd1);
      chk("post_active", {31'd0, tx_if.o_TX_Active}, 32'd0);
      chk("post_done", {31'd0, tx_if.o_TX_Done}, 32'd0);
      chk("post_ready", {31'd0, tx_if.o_TX_Ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    vec_t late;
    vecs[0] = '{data: 8'h5A, frame: 10'b0_01011010_1};
    vecs[1] = '{data: 8'h00, frame: 10'b0_00000000_1};
    vecs[2] = '{data: 8'hFF, frame: 10'b0_11111111_1};
    vecs[3] = '{data: 8'h01, frame: 10'b0_10000000_1};
    vecs[4] = '{data: 8'hC3, frame: 10'b0_11000011_1};
    late    = '{data: 8'hA5, frame: 10'b0_10100101_1};
    checks   = 0;
    failures = 0;

    // Reset values held while RST is high.
    RST             = 1'b1;
    tx_if.i_TX_DV   = 1'b0;
    tx_if.i_TX_Byte = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_serial", {31'd0, tx_if.o_TX_Serial}, 32'd1);
    chk("rst_active", {31'd0, tx_if.o_TX_Active}, 32'd0);
    chk("rst_done", {31'd0, tx_if.o_TX_Done}, 32'd0);
    chk("rst_overflow", {31'd0, tx_if.o_TX_Overflow}, 32'd0);
    chk("rst_ready", {31'd0, tx_if.o_TX_Ready}, 32'd1);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) send_single(vecs[i]);

    // Burst of six from idle, then a write coinciding with the pop of a full FIFO.
    clear_stream();
    for (int w = 0; w < 6; w++) begin
      wr_t[w] = w;
      wr_b[w] = 8'(w + 1);
    end
    wr_t[6] = 42; wr_b[6] = 8'hEE; n_wr = 7;
    for (int f = 0; f < 5; f++) begin
      fr_start[f] = 2 + 41 * f;
      fr_byte[f]  = 8'(f + 1);
    end
    n_fr = 5;
    ovf_t[0] = 5; ovf_t[1] = 42; n_ovf = 2;
    rdy_t[0] = 3;  rdy_v[0] = 1'b1;
    rdy_t[1] = 4;  rdy_v[1] = 1'b0;
    rdy_t[2] = 5;  rdy_v[2] = 1'b0;
    rdy_t[3] = 41; rdy_v[3] = 1'b0;
    rdy_t[4] = 42; rdy_v[4] = 1'b1;
    rdy_t[5] = 43; rdy_v[5] = 1'b1;
    n_rdy = 6;
    run_stream(2 + 41 * 5 + 6);

    // 0x00 then 0xFF written during its stop bit: one idle cycle between frames.
    clear_stream();
    wr_t[0] = 0;  wr_b[0] = 8'h00;
    wr_t[1] = 39; wr_b[1] = 8'hFF;
    n_wr = 2;
    fr_start[0] = 2;  fr_byte[0] = 8'h00;
    fr_start[1] = 43; fr_byte[1] = 8'hFF;
    n_fr = 2;
    rdy_t[0] = 39; rdy_v[0] = 1'b1;
    n_rdy = 1;
    run_stream(43 + 10 * Cpb + 3);

    // Reset during data bit 3 of 0xFF with two bytes queued.
    clear_stream();
    wr_t[0] = 0; wr_b[0] = 8'hFF;
    wr_t[1] = 1; wr_b[1] = 8'h11;
    wr_t[2] = 2; wr_b[2] = 8'h22;
    n_wr = 3;
    fr_start[0] = 2; fr_byte[0] = 8'hFF;
    n_fr = 1;
    run_stream(20);
    chk("midframe_active", {31'd0, tx_if.o_TX_Active}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("abort_serial", {31'd0, tx_if.o_TX_Serial}, 32'd1);
    chk("abort_active", {31'd0, tx_if.o_TX_Active}, 32'd0);
    chk("abort_ready", {31'd0, tx_if.o_TX_Ready}, 32'd1);
    chk("abort_done", {31'd0, tx_if.o_TX_Done}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    clear_stream();
    rdy_t[0] = 0; rdy_v[0] = 1'b1;
    n_rdy = 1;
    run_stream(60);

    // First write after reset keeps the normal latency.
    send_single(late);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
